// File: rtl/handshake_sequence_gen.sv
// Burst sequence source: each accepted control token emits LEN values START, START+STEP, ...
// Optional outs_last end-of-burst flag under HANDSHAKE_SEQUENCE_GEN_LAST_EN.
module handshake_sequence_gen #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int          START      = 0,
    parameter int          STEP       = 1,
    parameter int unsigned LEN        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
    ,
    output logic                  outs_last
`endif
);

    localparam int unsigned RemW = (LEN < 2) ? 1 : $clog2(LEN + 1);

    localparam logic [DATA_WIDTH-1:0] StartW = DATA_WIDTH'(START);
    localparam logic [DATA_WIDTH-1:0] StepW  = DATA_WIDTH'(STEP);
    localparam logic [RemW-1:0]       LenW   = RemW'(LEN);
    localparam logic [RemW-1:0]       OneW   = RemW'(1);

    if (LEN < 1) begin : g_bad_len
        $error("handshake_sequence_gen: LEN must be >= 1");
    end

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] val_q;
    logic [RemW-1:0]       rem_q;
    logic                  last_beat;

    // Final handshake of a burst frees the control port in the same cycle: no bubble.
    assign last_beat  = (state_q == StEmit) && (rem_q == OneW) && outs_ready;
    assign ctrl_ready = (state_q == StIdle) || last_beat;
    assign outs       = val_q;
    assign outs_valid = (state_q == StEmit);

`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
    assign outs_last  = (state_q == StEmit) && (rem_q == OneW);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            val_q   <= '0;
            rem_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl_valid) begin
                        val_q   <= StartW;
                        rem_q   <= LenW;
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    if (outs_ready) begin
                        if (rem_q == OneW) begin
                            if (ctrl_valid) begin
                                val_q <= StartW;
                                rem_q <= LenW;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            val_q <= val_q + StepW;
                            rem_q <= rem_q - OneW;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_sequence_gen.sv
// Directed bench for handshake_sequence_gen: wrap, backpressure, back-to-back bursts,
// degenerate constant source, asynchronous reset mid-burst, optional outs_last.
module tb_handshake_sequence_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A: DATA_WIDTH=12, START=FFD, STEP=1, LEN=4
    logic        ctrl_valid_a = 1'b0, ctrl_ready_a, outs_valid_a, outs_ready_a = 1'b0;
    logic [11:0] outs_a;
    // Instance B: LEN=3, START=5, STEP=-2
    logic        ctrl_valid_b = 1'b0, ctrl_ready_b, outs_valid_b, outs_ready_b = 1'b0;
    logic [11:0] outs_b;
    // Instance C: LEN=1, STEP=0, START=FFD
    logic        ctrl_valid_c = 1'b0, ctrl_ready_c, outs_valid_c, outs_ready_c = 1'b0;
    logic [11:0] outs_c;

`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
    logic outs_last_a, outs_last_b, outs_last_c;
`endif

    handshake_sequence_gen #(
        .DATA_WIDTH(12), .START(12'hFFD), .STEP(1), .LEN(4)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid_a),
        .ctrl_ready (ctrl_ready_a),
        .outs       (outs_a),
        .outs_valid (outs_valid_a),
        .outs_ready (outs_ready_a)
`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
        ,
        .outs_last  (outs_last_a)
`endif
    );

    handshake_sequence_gen #(
        .DATA_WIDTH(12), .START(5), .STEP(-2), .LEN(3)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid_b),
        .ctrl_ready (ctrl_ready_b),
        .outs       (outs_b),
        .outs_valid (outs_valid_b),
        .outs_ready (outs_ready_b)
`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
        ,
        .outs_last  (outs_last_b)
`endif
    );

    handshake_sequence_gen #(
        .DATA_WIDTH(12), .START(12'hFFD), .STEP(0), .LEN(1)
    ) u_dut_c (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid_c),
        .ctrl_ready (ctrl_ready_c),
        .outs       (outs_c),
        .outs_valid (outs_valid_c),
        .outs_ready (outs_ready_c)
`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
        ,
        .outs_last  (outs_last_c)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] seq1 [0:3];
    logic        rdy2 [0:6];
    logic [11:0] out2 [0:6];
    logic [11:0] hs2  [0:3];
    logic [11:0] seq3 [0:5];
    int          n_hs;

    initial begin
        seq1 = '{12'hFFD, 12'hFFE, 12'hFFF, 12'h000};
        rdy2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        out2 = '{12'hFFD, 12'hFFE, 12'hFFE, 12'hFFE, 12'hFFF, 12'h000, 12'h000};
        hs2  = '{12'hFFD, 12'hFFE, 12'hFFF, 12'h000};
        seq3 = '{12'h005, 12'h003, 12'h001, 12'h005, 12'h003, 12'h001};

        // Reset state
        #2;
        check_eq("rst_valid_a", 32'(outs_valid_a), 32'd0);
        check_eq("rst_outs_a",  32'(outs_a),       32'd0);
        check_eq("rst_ready_a", 32'(ctrl_ready_a), 32'd1);
        check_eq("rst_valid_b", 32'(outs_valid_b), 32'd0);
        check_eq("rst_ready_c", 32'(ctrl_ready_c), 32'd1);
`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
        check_eq("rst_last_a",  32'(outs_last_a),  32'd0);
`endif
        #10 rst = 1'b1;
        step();
        step();

        // Scenario 1: wrapping burst with continuous outs_ready
        ctrl_valid_a = 1'b1;
        outs_ready_a = 1'b1;
        @(negedge clk);
        check_eq("s1_acc_ready", 32'(ctrl_ready_a), 32'd1);
        check_eq("s1_acc_valid", 32'(outs_valid_a), 32'd0);
        step();
        ctrl_valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("s1_outs[%0d]", i),  32'(outs_a),       32'(seq1[i]));
            check_eq($sformatf("s1_valid[%0d]", i), 32'(outs_valid_a), 32'd1);
            check_eq($sformatf("s1_ready[%0d]", i), 32'(ctrl_ready_a), (i == 3) ? 32'd1 : 32'd0);
`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
            check_eq($sformatf("s1_last[%0d]", i),  32'(outs_last_a),  (i == 3) ? 32'd1 : 32'd0);
`endif
            step();
        end
        @(negedge clk);
        check_eq("s1_end_valid", 32'(outs_valid_a), 32'd0);
        check_eq("s1_end_ready", 32'(ctrl_ready_a), 32'd1);
`ifdef HANDSHAKE_SEQUENCE_GEN_LAST_EN
        check_eq("s1_end_last",  32'(outs_last_a),  32'd0);
`endif
        step();

        // Scenario 2: backpressure pattern 1,0,0,1,1,0,1
        ctrl_valid_a = 1'b1;
        step();
        ctrl_valid_a = 1'b0;
        n_hs = 0;
        for (int i = 0; i < 7; i++) begin
            outs_ready_a = rdy2[i];
            @(negedge clk);
            check_eq($sformatf("s2_outs[%0d]", i),  32'(outs_a),       32'(out2[i]));
            check_eq($sformatf("s2_valid[%0d]", i), 32'(outs_valid_a), 32'd1);
            if (outs_valid_a && outs_ready_a) begin
                if (n_hs < 4) check_eq($sformatf("s2_hs[%0d]", n_hs), 32'(outs_a), 32'(hs2[n_hs]));
                n_hs++;
            end
            step();
        end
        outs_ready_a = 1'b1;
        @(negedge clk);
        check_eq("s2_hs_count",  32'(n_hs),         32'd4);
        check_eq("s2_end_valid", 32'(outs_valid_a), 32'd0);
        step();

        // Scenario 3: back-to-back bursts, ctrl_valid held high
        ctrl_valid_b = 1'b1;
        outs_ready_b = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("s3_outs[%0d]", i),  32'(outs_b),       32'(seq3[i]));
            check_eq($sformatf("s3_valid[%0d]", i), 32'(outs_valid_b), 32'd1);
            check_eq($sformatf("s3_ready[%0d]", i), 32'(ctrl_ready_b),
                     (i == 2 || i == 5) ? 32'd1 : 32'd0);
            step();
        end
        ctrl_valid_b = 1'b0;
        step();
        step();
        step();
        @(negedge clk);
        check_eq("s3_end_valid", 32'(outs_valid_b), 32'd0);
        step();

        // Scenario 4: registered constant
        ctrl_valid_c = 1'b1;
        outs_ready_c = 1'b1;
        @(negedge clk);
        check_eq("s4_first_valid", 32'(outs_valid_c), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("s4_outs[%0d]", i),  32'(outs_c),       32'hFFD);
            check_eq($sformatf("s4_valid[%0d]", i), 32'(outs_valid_c), 32'd1);
            check_eq($sformatf("s4_ready[%0d]", i), 32'(ctrl_ready_c), 32'd1);
            step();
        end
        ctrl_valid_c = 1'b0;
        @(negedge clk);
        check_eq("s4_tail_valid", 32'(outs_valid_c), 32'd1);
        step();
        @(negedge clk);
        check_eq("s4_end_valid", 32'(outs_valid_c), 32'd0);
        step();

        // Scenario 5: asynchronous reset after the second token
        ctrl_valid_a = 1'b1;
        outs_ready_a = 1'b1;
        step();
        ctrl_valid_a = 1'b0;
        step();
        @(negedge clk);
        check_eq("s5_second", 32'(outs_a), 32'hFFE);
        step();
        #2 rst = 1'b0;
        #1;
        check_eq("s5_rst_valid", 32'(outs_valid_a), 32'd0);
        check_eq("s5_rst_ready", 32'(ctrl_ready_a), 32'd1);
        check_eq("s5_rst_outs",  32'(outs_a),       32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        ctrl_valid_a = 1'b1;
        step();
        ctrl_valid_a = 1'b0;
        @(negedge clk);
        check_eq("s5_restart_outs",  32'(outs_a),       32'hFFD);
        check_eq("s5_restart_valid", 32'(outs_valid_a), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
